// File: rtl/div_unit.sv
// Iterative RV32M div/divu/rem/remu unit: radix-2 restoring shift-subtract, 33-cycle latency.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip CALC (1-cycle latency).
//
// state | meaning
// IDLE  | waiting for enabled; completed drops here
// CALC  | one shift-subtract step per cycle, cnt 31 down to 0
// FIX   | sign correction / special-case override, result registered
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enabled,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            completed,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic            neg_q, neg_r;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;

  logic            signed_op;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic [XLEN:0]   rem_shift, rem_sub;
  logic            ge;
  logic            div_zero, ovf;
  logic [XLEN-1:0] fix_val;

  assign signed_op = ~op[0];
  assign rs1_mag   = (signed_op && rs1[XLEN-1]) ? -rs1 : rs1;
  assign rs2_mag   = (signed_op && rs2[XLEN-1]) ? -rs2 : rs2;

  // remainder < divisor always, so bit XLEN of the difference is the borrow
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_sub   = rem_shift - {1'b0, dvsr_q};
  assign ge        = ~rem_sub[XLEN];

  assign div_zero = (rs2_q == '0);
  assign ovf      = ~op_q[0] && (rs1_q == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_q);

  always_comb begin
    fix_val = quo_q;
    if (div_zero)      fix_val = op_q[1] ? rs1_q : '1;
    else if (ovf)      fix_val = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    else if (op_q[1])  fix_val = neg_r ? -rem_q : rem_q;
    else               fix_val = neg_q ? -quo_q : quo_q;
  end

`ifdef DIV_FAST_SPECIAL_EN
  logic accept_special;
  assign accept_special = (rs2 == '0) ||
                          (signed_op && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2));
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      completed <= 1'b0;
      result    <= '0;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      busy      <= 1'b0;
      completed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          completed <= 1'b0;
          if (enabled) begin
            op_q   <= op;
            rs1_q  <= rs1;
            rs2_q  <= rs2;
            neg_q  <= signed_op & (rs1[XLEN-1] ^ rs2[XLEN-1]);
            neg_r  <= signed_op & rs1[XLEN-1];
            quo_q  <= rs1_mag;
            rem_q  <= '0;
            dvsr_q <= rs2_mag;
            cnt    <= CW'(XLEN-1);
            busy   <= 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
            state  <= accept_special ? FIX : CALC;
`else
            state  <= CALC;
`endif
          end
        end
        CALC: begin
          rem_q <= ge ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], ge};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          result    <= fix_val;
          completed <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: arithmetic results, latency, flush/reset abort, back-to-back issue.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enabled;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        busy, completed;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .enabled(enabled), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy), .completed(completed), .result(result)
  );

  always #5 clk = ~clk;

  // Issues one op; returns result, cycles from accept to completed, and cycles busy was seen high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bcnt);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; enabled = 1'b1;
    @(posedge clk); #1;
    bcnt = busy ? 1 : 0;
    lat  = 0;
    @(negedge clk);
    enabled = 1'b0;
    while (!completed && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
      n_vec++;
      if (busy && completed) begin
        n_err++;
        $display("FAIL overlap: busy=%b completed=%b at cycle %0d, required not both 1", busy, completed, lat);
      end
    end
    n_vec++;
    if (!completed) begin
      n_err++;
      $display("FAIL timeout: completed not seen within %0d cycles", lat);
    end
    res = result;
  endtask

  task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] r;
    int lat, bc;
    run_op(o, a, b, r, lat, bc);
    n_vec++;
    if (r !== exp) begin
      n_err++;
      $display("FAIL %s result: got %h, required %h", name, r, exp);
    end
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (bc !== exp_lat) begin
      n_err++;
      $display("FAIL %s busy cycles: got %0d, required %0d", name, bc, exp_lat);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; enabled = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || completed !== 1'b0 || result !== 32'h0) begin
      n_err++;
      $display("FAIL reset: busy=%b completed=%b result=%h, required 0 0 00000000", busy, completed, result);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_signed;
    check_op("div -7/2",    OP_DIV, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33);
    check_op("rem -7%2",    OP_REM, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33);
    check_op("div 100/-7",  OP_DIV, 32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2, 33);
    check_op("rem 100%-7",  OP_REM, 32'd100,       32'hFFFF_FFF9,  32'd2,         33);
    check_op("div -100/-7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14,        33);
  endtask

  task automatic test_unsigned;
    check_op("divu fffffffe/3", OP_DIVU, 32'hFFFF_FFFE, 32'd3, 32'h5555_5554, 33);
    check_op("remu fffffffe%3", OP_REMU, 32'hFFFF_FFFE, 32'd3, 32'd2,         33);
    check_op("divu 7/9",        OP_DIVU, 32'd7,         32'd9, 32'd0,         33);
  endtask

  task automatic test_div_zero;
    check_op("div -5/0",  OP_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
    check_op("rem -5%0",  OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPECIAL_LAT);
    check_op("divu 9/0",  OP_DIVU, 32'd9,         32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
    check_op("remu 9%0",  OP_REMU, 32'd9,         32'd0, 32'd9,         SPECIAL_LAT);
  endtask

  task automatic test_overflow;
    check_op("div ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);
    check_op("rem ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         SPECIAL_LAT);
    check_op("divu big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         33);
  endtask

  // abort_with_reset=0 pulses flush at E10, otherwise drives rstn=0 at E10
  task automatic test_abort(input bit abort_with_reset);
    logic [31:0] exp_res;
    bit seen;
    string name;
    name = abort_with_reset ? "reset-abort" : "flush-abort";
    check_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    exp_res = abort_with_reset ? 32'h0 : 32'd14;
    @(negedge clk);
    op = OP_DIVU; rs1 = 32'd50; rs2 = 32'd5; enabled = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy at E9: got %b, required 1", name, busy);
    end
    @(negedge clk);
    if (abort_with_reset) rstn = 1'b0;
    else                  flush = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || completed !== 1'b0 || result !== exp_res) begin
      n_err++;
      $display("FAIL %s after E10: busy=%b completed=%b result=%h, required 0 0 %h",
               name, busy, completed, result, exp_res);
    end
    @(negedge clk);
    flush = 1'b0; rstn = 1'b1; enabled = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (completed) seen = 1'b1;
    end
    n_vec++;
    if (seen || result !== exp_res) begin
      n_err++;
      $display("FAIL %s aftermath: completed seen=%b result=%h, required 0 %h", name, seen, result, exp_res);
    end
  endtask

  task automatic test_back_to_back;
    int c1, c2;
    logic [31:0] r1, r2;
    c1 = -1; c2 = -1; r1 = '0; r2 = '0;
    @(negedge clk);
    op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; enabled = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rs1 = 32'd1000; rs2 = 32'd10;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk); #1;
      if (completed) begin
        if (c1 < 0)      begin c1 = cyc; r1 = result; end
        else if (c2 < 0) begin c2 = cyc; r2 = result; end
      end
      if (cyc == 33) begin
        n_vec++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL b2b busy at E33: got %b, required 0", busy);
        end
      end
      if (cyc == 34) begin
        n_vec++;
        if (busy !== 1'b1 || completed !== 1'b0) begin
          n_err++;
          $display("FAIL b2b second accept at E34: busy=%b completed=%b, required 1 0", busy, completed);
        end
        enabled = 1'b0;
      end
    end
    n_vec++;
    if (c1 != 33 || r1 !== 32'd14) begin
      n_err++;
      $display("FAIL b2b first: cycle %0d result %h, required 33 0000000e", c1, r1);
    end
    n_vec++;
    if (c2 != 67 || r2 !== 32'd100) begin
      n_err++;
      $display("FAIL b2b second: cycle %0d result %h, required 67 00000064", c2, r2);
    end
  endtask

  initial begin
    test_reset;
    test_signed;
    test_unsigned;
    test_div_zero;
    test_overflow;
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
